crc32_rx_check: RTL and testbench

Receive-side CRC-32 frame checker for the reflected Ethernet polynomial (0xEDB88320, right-shifting, 8-bit input). It sits on the inbound byte stream after deframing. It runs every accepted byte through the byte-wise CRC update and forwards the bytes downstream. At end-of-frame it compares the register against the good-frame residue and reports pass/fail. When stripping is compiled in, it removes the trailing 4-byte FCS from the forwarded stream.

---
 rtl/crc32_pkg.sv | 15 +
 rtl/crc32_d8.sv | 20 ++
 rtl/crc32_rx_check.sv | 122 ++++++++++++
 tb/tb_crc32_rx_check.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/crc32_pkg.sv
// Shared constants for the receive-side CRC-32 checker (reflected 0xEDB88320, byte-wise).
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

  // Shortest legal frame in bytes, FCS included.
  localparam logic [3:0] MIN_LEN_STRIP   = 4'd5;
  localparam logic [3:0] MIN_LEN_NOSTRIP = 4'd4;

  localparam logic [2:0] CNT_MAX   = 3'd5;
  localparam logic [2:0] FILL_FULL = 3'd4;

endpackage

// File: rtl/crc32_d8.sv
// Combinational one-byte update of the reflected CRC-32 register (bit 0 of data first).
module crc32_d8
  import crc32_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  always_comb begin
    c = crc_i ^ {24'h0, data_i};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/crc32_rx_check.sv
// Receive CRC-32 frame checker with byte forwarding and end-of-frame status.
// Define CRC32_RX_STRIP_EN to remove the trailing 4-byte FCS from the forwarded stream.
module crc32_rx_check
  import crc32_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       s_valid_i,
  input  logic [7:0] s_data_i,
  input  logic       s_last_i,
  output logic       s_ready_o,
  output logic       m_valid_o,
  output logic [7:0] m_data_o,
  output logic       m_last_o,
  input  logic       m_ready_i,
  output logic       status_valid_o,
  output logic       crc_ok_o,
  output logic       runt_o
);

`ifdef CRC32_RX_STRIP_EN
  localparam logic [3:0] MinLen = MIN_LEN_STRIP;
`else
  localparam logic [3:0] MinLen = MIN_LEN_NOSTRIP;
`endif

  logic        accept;
  logic [31:0] crc_q, crc_next;
  logic [2:0]  cnt_q;
  logic        runt;
  logic        emit;
  logic [7:0]  emit_data;
  logic        m_valid_q, m_last_q;
  logic [7:0]  m_data_q;
  logic        status_valid_q, crc_ok_q, runt_q;

  // Output register is the only backpressure source, so ready never depends on s_valid_i.
  assign s_ready_o = !m_valid_q | m_ready_i;
  assign accept    = s_valid_i & s_ready_o;

  crc32_d8 u_crc32_d8 (
    .crc_i  (crc_q),
    .data_i (s_data_i),
    .crc_o  (crc_next)
  );

  assign runt = (({1'b0, cnt_q}) + 4'd1) < MinLen;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q          <= CRC32_INIT;
      cnt_q          <= '0;
      status_valid_q <= 1'b0;
      crc_ok_q       <= 1'b0;
      runt_q         <= 1'b0;
    end else begin
      status_valid_q <= accept & s_last_i;
      if (accept) begin
        if (s_last_i) begin
          crc_q    <= CRC32_INIT;
          cnt_q    <= '0;
          crc_ok_q <= (crc_next == CRC32_RESIDUE) & !runt;
          runt_q   <= runt;
        end else begin
          crc_q <= crc_next;
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 3'd1;
        end
      end
    end
  end

`ifdef CRC32_RX_STRIP_EN
  logic [7:0] fifo_q [4];
  logic [2:0] fill_q;

  // Bytes leave only once four newer ones exist, so the FCS is never emitted.
  assign emit      = accept & (fill_q == FILL_FULL);
  assign emit_data = fifo_q[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fill_q <= '0;
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
    end else if (accept) begin
      if (s_last_i) begin
        fill_q <= '0;
      end else if (fill_q == FILL_FULL) begin
        for (int i = 0; i < 3; i++) fifo_q[i] <= fifo_q[i+1];
        fifo_q[3] <= s_data_i;
      end else begin
        fifo_q[fill_q[1:0]] <= s_data_i;
        fill_q              <= fill_q + 3'd1;
      end
    end
  end
`else
  assign emit      = accept;
  assign emit_data = s_data_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else if (s_ready_o) begin
      m_valid_q <= emit;
      if (emit) begin
        m_data_q <= emit_data;
        m_last_q <= s_last_i;
      end
    end
  end

  assign m_valid_o      = m_valid_q;
  assign m_data_o       = m_data_q;
  assign m_last_o       = m_last_q;
  assign status_valid_o = status_valid_q;
  assign crc_ok_o       = crc_ok_q;
  assign runt_o         = runt_q;

endmodule

// File: tb/tb_crc32_rx_check.sv
// Self-checking bench for crc32_rx_check: scoreboard of forwarded bytes and frame status.
module tb_crc32_rx_check;

`ifdef CRC32_RX_STRIP_EN
  localparam int MinLen = 5;
`else
  localparam int MinLen = 4;
`endif

  logic       clk_i, rst_ni;
  logic       s_valid_i, s_last_i, s_ready_o;
  logic [7:0] s_data_i;
  logic       m_valid_o, m_last_o, m_ready_i;
  logic [7:0] m_data_o;
  logic       status_valid_o, crc_ok_o, runt_o;

  crc32_rx_check dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .s_valid_i      (s_valid_i),
    .s_data_i       (s_data_i),
    .s_last_i       (s_last_i),
    .s_ready_o      (s_ready_o),
    .m_valid_o      (m_valid_o),
    .m_data_o       (m_data_o),
    .m_last_o       (m_last_o),
    .m_ready_i      (m_ready_i),
    .status_valid_o (status_valid_o),
    .crc_ok_o       (crc_ok_o),
    .runt_o         (runt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {logic last; logic [7:0] data;} beat_t;
  typedef struct packed {logic ok; logic runt;} stat_t;

  beat_t exp_q[$];
  stat_t stat_q[$];
  int    errors = 0;
  int    checks = 0;
  bit    status_due = 0;
  bit    rand_ready = 0;
  bit    held = 0;
  beat_t held_beat;
  beat_t e;
  stat_t s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_ref(input logic [7:0] b[$], input int n);
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  always @(posedge clk_i) begin
    #1;
    m_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      chk("status_timing", {31'h0, status_valid_o}, {31'h0, status_due});
      status_due = 0;
      if (status_valid_o) begin
        if (stat_q.size() == 0) chk("status_extra", stat_q.size(), 1);
        else begin
          s = stat_q.pop_front();
          chk("crc_ok", {31'h0, crc_ok_o}, {31'h0, s.ok});
          chk("runt", {31'h0, runt_o}, {31'h0, s.runt});
        end
      end
      if (held) begin
        chk("hold_valid", {31'h0, m_valid_o}, 32'h1);
        chk("hold_data", {23'h0, m_last_o, m_data_o}, {23'h0, held_beat});
      end
      if (m_valid_o && m_ready_i) begin
        held = 0;
        if (exp_q.size() == 0) chk("out_extra", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          chk("out_data", {23'h0, m_last_o, m_data_o}, {23'h0, e});
        end
      end else if (m_valid_o) begin
        held = 1;
        held_beat = {m_last_o, m_data_o};
      end else begin
        held = 0;
      end
    end else begin
      held = 0;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l, input int gap);
    int budget = 0;
    if (gap > 0) begin
      s_valid_i = 1'b0;
      repeat (gap) begin @(posedge clk_i); #1; end
    end
    s_valid_i = 1'b1;
    s_data_i  = d;
    s_last_i  = l;
    forever begin
      @(posedge clk_i);
      if (s_ready_o) break;
      budget++;
      if (budget > 200) begin
        chk("accept_timeout", budget, 0);
        break;
      end
    end
    if (l) status_due = 1;
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b[$], input bit with_last, input int maxgap);
    int n = b.size();
    stat_t st;
`ifdef CRC32_RX_STRIP_EN
    for (int i = 0; i + 4 < n; i++) exp_q.push_back({with_last && (i == n - 5), b[i]});
`else
    for (int i = 0; i < n; i++) exp_q.push_back({with_last && (i == n - 1), b[i]});
`endif
    if (with_last) begin
      st.runt = (n < MinLen);
      st.ok   = !st.runt && (crc_ref(b, n - 4) == {b[n-1], b[n-2], b[n-3], b[n-4]});
      stat_q.push_back(st);
    end
    for (int i = 0; i < n; i++)
      send_byte(b[i], with_last && (i == n - 1), (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
  endtask

  task automatic idle(input int n);
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || stat_q.size() != 0) && t < 500) begin
      @(posedge clk_i);
      t++;
    end
    #1;
    chk("drain", exp_q.size() + stat_q.size(), 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_s_ready", {31'h0, s_ready_o}, 32'h1);
    chk("rst_m_valid", {31'h0, m_valid_o}, 32'h0);
    chk("rst_m_data", {24'h0, m_data_o}, 32'h0);
    chk("rst_m_last", {31'h0, m_last_o}, 32'h0);
    chk("rst_status", {31'h0, status_valid_o}, 32'h0);
    chk("rst_crc_ok", {31'h0, crc_ok_o}, 32'h0);
    chk("rst_runt", {31'h0, runt_o}, 32'h0);
  endtask

  logic [7:0] good[$];
  logic [7:0] bad[$];
  logic [7:0] runt3[$];
  logic [7:0] part6[$];

  initial begin
    good  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'h26, 8'h39, 8'hF4, 8'hCB};
    bad   = good;
    bad[4] = 8'h34;
    runt3 = '{8'hAA, 8'hBB, 8'hCC};
    part6 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};

    rst_ni = 1'b0; s_valid_i = 1'b0; s_data_i = '0; s_last_i = 1'b0; m_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk_reset_vals();
    rst_ni = 1'b1;
    idle(2);

    // Good frame, always ready
    send_frame(good, 1, 0);
    idle(2);
    drain();

    // Corrupted payload byte
    send_frame(bad, 1, 0);
    idle(2);
    drain();

    // Random input gaps and downstream stalls
    rand_ready = 1;
    send_frame(good, 1, 3);
    idle(2);
    drain();
    rand_ready = 0;
    idle(2);

    // Runt frame
    send_frame(runt3, 1, 0);
    idle(2);
    drain();

    // Back-to-back frames with no idle cycle
    send_frame(good, 1, 0);
    send_frame(good, 1, 0);
    idle(2);
    drain();

    // Reset mid-frame, then a clean frame
    send_frame(part6, 0, 0);
    idle(0);
    @(negedge clk_i);
    #1;
    chk("pre_reset_drained", exp_q.size(), 0);
    exp_q.delete();
    rst_ni = 1'b0;
    #1;
    chk_reset_vals();
    @(negedge clk_i);
    #1;
    chk_reset_vals();
    rst_ni = 1'b1;
    idle(1);
    send_frame(good, 1, 0);
    idle(2);
    drain();
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
